// File: rtl/corr_count_multi.sv
// Multi-channel windowed correlation counter: log-drop weighted x/y counts over
// self-timed 2^L-cycle windows, each finished window captured into a valid/ready snapshot.
module corr_count_multi #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int TIME_W = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           i_enable,
  input  logic [$clog2(TIME_W+1)-1:0]    i_windowLengthExp,
  input  logic [N_CH-1:0]                i_x,
  input  logic                           i_y,
  output logic                           o_busy,
  output logic [TIME_W-1:0]              o_t,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_missed,
  output logic [N_CH*DATA_W-1:0]         o_countX,
  output logic [DATA_W-1:0]              o_countY,
  output logic [N_CH*DATA_W-1:0]         o_countIsect,
  output logic [N_CH*DATA_W-1:0]         o_countSymdiff
);

  localparam int LW = $clog2(TIME_W+1);
  localparam int WW = DATA_W - TIME_W;
  localparam logic [LW-1:0] LMAX   = LW'(TIME_W);
  localparam logic [LW-1:0] ONE_L  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] MAXW   = {WW{1'b1}};
  localparam logic [TIME_W-1:0] ONE_T = {{(TIME_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_r, state_next_s;
  logic [LW-1:0]          lq_r, l_clamp_s, shift_s, k_s;
  logic [TIME_W-1:0]      t_r, s_s;
  logic [DATA_W-1:0]      w_s;
  logic                   last_s, load_s, latch_s, accept_s;
  logic                   valid_r, missed_r;
  logic [N_CH*DATA_W-1:0] cnt_x_r, cnt_i_r, cnt_d_r;
  logic [N_CH*DATA_W-1:0] sum_x_s, sum_i_s, sum_d_s;
  logic [DATA_W-1:0]      cnt_y_r, sum_y_s;
  logic [N_CH*DATA_W-1:0] snap_x_r, snap_i_r, snap_d_r;
  logic [DATA_W-1:0]      snap_y_r;

  // Run of consecutive ones from the MSB down; this is the log-drop exponent.
  function automatic logic [LW-1:0] lead_ones(input logic [TIME_W-1:0] v);
    logic [LW-1:0] n;
    logic          run;
    n   = {LW{1'b0}};
    run = 1'b1;
    for (int i = TIME_W-1; i >= 0; i--) begin
      if (run && v[i]) n = n + ONE_L;
      else             run = 1'b0;
    end
    return n;
  endfunction

  // Weight for the current window position and window-end detect.
  always_comb begin
    l_clamp_s = (i_windowLengthExp > LMAX) ? LMAX : i_windowLengthExp;
    shift_s   = LMAX - lq_r;
    s_s       = t_r << shift_s;
    k_s       = lead_ones(s_s);
    w_s       = {{TIME_W{1'b0}}, MAXW >> k_s};
    last_s    = (t_r == ({TIME_W{1'b1}} >> shift_s));
  end

  // Next-state logic; a window in progress always runs to completion.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    latch_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_enable) begin
          state_next_s = RUN;
          latch_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          load_s = 1'b1;
          if (i_enable) begin
            latch_s      = 1'b1;
            state_next_s = RUN;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Working sums including this cycle's samples.
  always_comb begin
    sum_y_s = cnt_y_r + (i_y ? w_s : {DATA_W{1'b0}});
    sum_x_s = cnt_x_r;
    sum_i_s = cnt_i_r;
    sum_d_s = cnt_d_r;
    for (int c = 0; c < N_CH; c++) begin
      sum_x_s[c*DATA_W +: DATA_W] = cnt_x_r[c*DATA_W +: DATA_W] + (i_x[c] ? w_s : {DATA_W{1'b0}});
      sum_i_s[c*DATA_W +: DATA_W] = cnt_i_r[c*DATA_W +: DATA_W] + ((i_x[c] & i_y) ? w_s : {DATA_W{1'b0}});
      sum_d_s[c*DATA_W +: DATA_W] = cnt_d_r[c*DATA_W +: DATA_W] + ((i_x[c] ^ i_y) ? w_s : {DATA_W{1'b0}});
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_r <= IDLE;
    else         state_r <= state_next_s;
  end

  // Window time and the window length latched at each window start.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      t_r  <= {TIME_W{1'b0}};
      lq_r <= {LW{1'b0}};
    end else begin
      if (latch_s) lq_r <= l_clamp_s;
      if (state_r == RUN && !last_s) t_r <= t_r + ONE_T;
      else                           t_r <= {TIME_W{1'b0}};
    end
  end

  // Working counters, cleared as the finished window moves to the snapshot.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_x_r <= {(N_CH*DATA_W){1'b0}};
      cnt_i_r <= {(N_CH*DATA_W){1'b0}};
      cnt_d_r <= {(N_CH*DATA_W){1'b0}};
      cnt_y_r <= {DATA_W{1'b0}};
    end else if (state_r == RUN) begin
      if (last_s) begin
        cnt_x_r <= {(N_CH*DATA_W){1'b0}};
        cnt_i_r <= {(N_CH*DATA_W){1'b0}};
        cnt_d_r <= {(N_CH*DATA_W){1'b0}};
        cnt_y_r <= {DATA_W{1'b0}};
      end else begin
        cnt_x_r <= sum_x_s;
        cnt_i_r <= sum_i_s;
        cnt_d_r <= sum_d_s;
        cnt_y_r <= sum_y_s;
      end
    end
  end

  // Snapshot register, only written at a window end.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      snap_x_r <= {(N_CH*DATA_W){1'b0}};
      snap_i_r <= {(N_CH*DATA_W){1'b0}};
      snap_d_r <= {(N_CH*DATA_W){1'b0}};
      snap_y_r <= {DATA_W{1'b0}};
    end else if (load_s) begin
      snap_x_r <= sum_x_s;
      snap_i_r <= sum_i_s;
      snap_d_r <= sum_d_s;
      snap_y_r <= sum_y_s;
    end
  end

  assign accept_s = valid_r & i_ready;

  // Handshake flags; a load coinciding with an accept is not an overrun.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_r  <= 1'b0;
      missed_r <= 1'b0;
    end else if (load_s) begin
      valid_r  <= 1'b1;
      missed_r <= valid_r & ~i_ready;
    end else if (accept_s) begin
      valid_r  <= 1'b0;
      missed_r <= 1'b0;
    end
  end

  assign o_busy         = (state_r == RUN);
  assign o_t            = t_r;
  assign o_valid        = valid_r;
  assign o_missed       = missed_r;
  assign o_countX       = snap_x_r;
  assign o_countY       = snap_y_r;
  assign o_countIsect   = snap_i_r;
  assign o_countSymdiff = snap_d_r;

endmodule

// File: tb/tb_corr_count_multi.sv
// Directed self-checking bench for corr_count_multi (N_CH=2, DATA_W=16, TIME_W=8).
module tb_corr_count_multi;
  localparam int N_CH = 2, DATA_W = 16, TIME_W = 8;

  logic clk = 1'b0;
  logic rstn, en, y, ready;
  logic [3:0] lexp;
  logic [1:0] x;
  logic busy, valid, missed;
  logic [TIME_W-1:0] t;
  logic [N_CH*DATA_W-1:0] cx, ci, cs;
  logic [DATA_W-1:0] cy;
  int n_tests = 0, n_fail = 0;

  wire [15:0] cx0 = cx[15:0], cx1 = cx[31:16];
  wire [15:0] ci0 = ci[15:0], ci1 = ci[31:16];
  wire [15:0] cs0 = cs[15:0], cs1 = cs[31:16];

  corr_count_multi #(.N_CH(N_CH), .DATA_W(DATA_W), .TIME_W(TIME_W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en), .i_windowLengthExp(lexp),
    .i_x(x), .i_y(y), .o_busy(busy), .o_t(t), .o_valid(valid), .i_ready(ready),
    .o_missed(missed), .o_countX(cx), .o_countY(cy), .o_countIsect(ci), .o_countSymdiff(cs)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stop the window sequence and drain the snapshot; to=1 if it never settles.
  task automatic wait_idle(output bit to);
    en = 1'b0; ready = 1'b1; to = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy && !valid) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; lexp = 4'd0; x = 2'b00; y = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if ({busy, valid, missed, t} !== 11'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 0", {busy, valid, missed, t}); end
    n_tests++; if ({cx, ci, cs, cy} !== 112'd0) begin n_fail++; $display("FAIL reset_counts: got %h want 0", {cx, ci, cs, cy}); end
    rstn = 1'b1;
    @(negedge clk);
    n_tests++; if ({busy, valid} !== 2'b00) begin n_fail++; $display("FAIL reset_release: got %b want 00", {busy, valid}); end
  endtask

  task automatic test_basic_l2();
    bit to;
    logic exp_v;
    lexp = 4'd2; x = 2'b11; y = 1'b1; ready = 1'b1; en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      exp_v = (k >= 5) && ((k % 4) == 1);
      n_tests++; if (valid !== exp_v) begin n_fail++; $display("FAIL l2_valid k=%0d: got %b want %b", k, valid, exp_v); end
      n_tests++; if (t !== 8'((k-1) % 4)) begin n_fail++; $display("FAIL l2_t k=%0d: got %0d want %0d", k, t, (k-1) % 4); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL l2_busy k=%0d: got %b want 1", k, busy); end
      if (exp_v) begin
        n_tests++; if ({cx0, cx1, ci0, ci1, cy} !== {5{16'd700}}) begin n_fail++; $display("FAIL l2_sums k=%0d: got %0d %0d %0d %0d %0d want 700", k, cx0, cx1, ci0, ci1, cy); end
        n_tests++; if ({cs0, cs1} !== 32'd0) begin n_fail++; $display("FAIL l2_symdiff k=%0d: got %0d %0d want 0", k, cs0, cs1); end
      end
    end
    wait_idle(to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL l2_idle: timed out"); end
  endtask

  task automatic test_l8();
    bit to;
    int cyc;
    for (int pass = 0; pass < 2; pass++) begin
      // second pass uses an out-of-range exponent, which must clamp to 8
      lexp = (pass == 0) ? 4'd8 : 4'd15; x = 2'b01; y = 1'b0; ready = 1'b1; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      cyc = 1;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk); cyc++;
        if (valid) break;
      end
      n_tests++; if (cyc !== 257) begin n_fail++; $display("FAIL l8_period p=%0d: got %0d want 257", pass, cyc); end
      n_tests++; if ({cx0, cs0} !== {16'd43435, 16'd43435}) begin n_fail++; $display("FAIL l8_x0 p=%0d: got %0d %0d want 43435", pass, cx0, cs0); end
      n_tests++; if ({cx1, cs1, ci0, ci1, cy} !== 80'd0) begin n_fail++; $display("FAIL l8_zero p=%0d: got %0d %0d %0d %0d %0d want 0", pass, cx1, cs1, ci0, ci1, cy); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL l8_busy p=%0d: got %b want 0", pass, busy); end
      wait_idle(to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL l8_idle p=%0d: timed out", pass); end
    end
  endtask

  task automatic test_l0();
    bit to;
    logic [15:0] exp_y;
    lexp = 4'd0; x = 2'b00; y = 1'b0; ready = 1'b1; en = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      y = 1'(k % 2);
      @(negedge clk);
      exp_y = y ? 16'd255 : 16'd0;
      n_tests++; if ({valid, missed} !== 2'b10) begin n_fail++; $display("FAIL l0_flags k=%0d: got %b want 10", k, {valid, missed}); end
      n_tests++; if (cy !== exp_y) begin n_fail++; $display("FAIL l0_y k=%0d: got %0d want %0d", k, cy, exp_y); end
      n_tests++; if (cs0 !== exp_y) begin n_fail++; $display("FAIL l0_symdiff k=%0d: got %0d want %0d", k, cs0, exp_y); end
      n_tests++; if (t !== 8'd0) begin n_fail++; $display("FAIL l0_t k=%0d: got %0d want 0", k, t); end
    end
    wait_idle(to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL l0_idle: timed out"); end
  endtask

  task automatic test_overrun();
    lexp = 4'd1; x = 2'b01; y = 1'b1; ready = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if ({valid, missed, cx0, cx1} !== {2'b10, 16'd382, 16'd0}) begin n_fail++; $display("FAIL ovr_w1: got v=%b m=%b %0d %0d want 1 0 382 0", valid, missed, cx0, cx1); end
    x = 2'b10;
    @(negedge clk);
    n_tests++; if ({valid, cx0} !== {1'b1, 16'd382}) begin n_fail++; $display("FAIL ovr_hold: got v=%b %0d want 1 382", valid, cx0); end
    @(negedge clk);
    n_tests++; if ({valid, missed, cx0, cx1} !== {2'b11, 16'd0, 16'd382}) begin n_fail++; $display("FAIL ovr_w2: got v=%b m=%b %0d %0d want 1 1 0 382", valid, missed, cx0, cx1); end
    x = 2'b11; en = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if ({valid, missed, cx0, cx1, cy} !== {2'b11, 16'd382, 16'd382, 16'd382}) begin n_fail++; $display("FAIL ovr_w3: got v=%b m=%b %0d %0d %0d want 1 1 382 382 382", valid, missed, cx0, cx1, cy); end
    ready = 1'b1;
    @(negedge clk);
    n_tests++; if ({valid, missed, busy} !== 3'b000) begin n_fail++; $display("FAIL ovr_accept: got %b want 000", {valid, missed, busy}); end
  endtask

  task automatic test_stop_lchange();
    bit to;
    int nv;
    lexp = 4'd3; x = 2'b01; y = 1'b0; ready = 1'b1; en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 2) begin
        n_tests++; if (t !== 8'd1) begin n_fail++; $display("FAIL stop_t1: got %0d want 1", t); end
        en = 1'b0; lexp = 4'd1;
      end
      if (k == 8) begin
        n_tests++; if ({t, busy, valid} !== {8'd7, 2'b10}) begin n_fail++; $display("FAIL stop_t7: got t=%0d b=%b v=%b want 7 1 0", t, busy, valid); end
      end
      if (k == 9) begin
        n_tests++; if ({valid, busy, cx0} !== {2'b10, 16'd1368}) begin n_fail++; $display("FAIL stop_snap: got v=%b b=%b %0d want 1 0 1368", valid, busy, cx0); end
      end
    end
    nv = 0;
    repeat (10) begin @(negedge clk); if (valid || busy) nv++; end
    n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL stop_quiet: got %0d active cycles want 0", nv); end
    lexp = 4'd1; en = 1'b1;
    @(negedge clk);
    lexp = 4'd2;
    repeat (2) @(negedge clk);
    n_tests++; if ({valid, busy, cx0} !== {2'b11, 16'd382}) begin n_fail++; $display("FAIL lchg_w1: got v=%b b=%b %0d want 1 1 382", valid, busy, cx0); end
    en = 1'b0;
    nv = 0;
    repeat (3) begin @(negedge clk); if (valid) nv++; end
    n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL lchg_gap: got %0d valid cycles want 0", nv); end
    @(negedge clk);
    n_tests++; if ({valid, busy, cx0} !== {2'b10, 16'd700}) begin n_fail++; $display("FAIL lchg_w2: got v=%b b=%b %0d want 1 0 700", valid, busy, cx0); end
    wait_idle(to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL lchg_idle: timed out"); end
  endtask

  task automatic test_reset_mid();
    bit to;
    lexp = 4'd2; x = 2'b11; y = 1'b1; ready = 1'b0; en = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++; if ({valid, t} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL rmid_pre: got v=%b t=%0d want 1 1", valid, t); end
    #2 rstn = 1'b0;
    #1;
    n_tests++; if ({busy, valid, missed, t} !== 11'd0) begin n_fail++; $display("FAIL rmid_flags: got %b want 0", {busy, valid, missed, t}); end
    n_tests++; if ({cx, ci, cs, cy} !== 112'd0) begin n_fail++; $display("FAIL rmid_counts: got %h want 0", {cx, ci, cs, cy}); end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rmid_novalid k=%0d: got %b want 0", k, valid); end
      end else begin
        n_tests++; if ({valid, cx0, cy} !== {1'b1, 16'd700, 16'd700}) begin n_fail++; $display("FAIL rmid_first: got v=%b %0d %0d want 1 700 700", valid, cx0, cy); end
      end
    end
    wait_idle(to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: timed out"); end
  endtask

  initial begin
    test_reset();
    test_basic_l2();
    test_l8();
    test_l0();
    test_overrun();
    test_stop_lchange();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/corr_count_multi.md
# corr_count_multi

Multi-channel, self-sequencing windowed correlation counter for the correlator datapath. Accumulates log-drop-weighted counts of N_CH independent x channels against one shared y channel over back-to-back windows of length 2^L cycles. It generates window time internally and captures each finished window into a snapshot register drained by a valid/ready handshake, so a slow reader never corrupts a window in progress.

## Interface
Parameters:
- N_CH, 4, number of x channels (≥1)
- DATA_W, 16, counter width
- TIME_W, 8, window time precision; maximum window length 2^TIME_W; DATA_W > TIME_W

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_enable  in  1  1 = run windows continuously; 0 = stop after the current window
- i_windowLengthExp  in  $clog2(TIME_W+1)  L, 0..TIME_W; latched at each window start
- i_x  in  N_CH  sample per x channel
- i_y  in  1  shared y sample
- o_busy  out  1  FSM in RUN
- o_t  out  TIME_W  current window time t
- o_valid  out  1  snapshot available
- i_ready  in  1  consumer accepts snapshot
- o_missed  out  1  ≥1 snapshot overwritten since the last accepted one
- o_countX  out  N_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
- o_countY  out  DATA_W  snapshot y count
- o_countIsect  out  N_CH*DATA_W  x AND y
- o_countSymdiff  out  N_CH*DATA_W  x XOR y

## Operation
- FSM states:
  - IDLE: t = 0; counts held at 0.
  - RUN.
- IDLE→RUN on i_enable=1. At this transition t←0 and Lq←i_windowLengthExp.
- Weight:
  - MAXW = 2^(DATA_W-TIME_W)-1.
  - s = (t << (TIME_W-Lq)) truncated to TIME_W bits.
  - k = number of consecutive 1s in s counting from the MSB (0..TIME_W).
  - w = MAXW >> k, zero-extended to DATA_W.
- Each RUN cycle, per channel c:
  - countX[c] += w if x[c].
  - countIsect[c] += w if x[c]&y.
  - countSymdiff[c] += w if x[c]^y.
  - countY += w if y.
- Window end is the RUN cycle where t = 2^Lq-1. On that edge:
  - The snapshot loads the final sums, including that cycle's contribution.
  - Working counts are cleared and t←0.
  - If i_enable=1: Lq relatches and RUN continues with no gap cycle. Otherwise the FSM goes to IDLE.
- i_enable=0 mid-window does not truncate the window; a partial window never produces a snapshot.
- Overflow cannot occur: the worst-case sum is below 2^TIME_W·MAXW < 2^DATA_W. No saturation logic.
- Handshake:
  - o_valid sets on a snapshot load.
  - o_valid clears on an edge with o_valid&i_ready and no simultaneous load.
  - Snapshot outputs are stable while o_valid=1 and not accepted.
- Overrun:
  - A load while o_valid=1 and i_ready=0 overwrites the snapshot and sets o_missed.
  - A load in the same cycle as an accept is not an overrun; o_valid stays 1.
  - o_missed describes the current snapshot and clears when that snapshot is accepted. If the accept coincides with a non-overrun load, o_missed←0.
- i_windowLengthExp changes mid-window are ignored until the next window start. Values >TIME_W are clamped to TIME_W.

## Timing
- Reset (async assert, sync-safe release) sets:
  - FSM = IDLE, t = 0, Lq = 0.
  - All working counts and all snapshot counts = 0.
  - o_valid = 0, o_missed = 0, o_busy = 0, o_t = 0.
- A sample present on a RUN cycle is reflected in the working counts after that edge; there is no input pipeline.
- First RUN cycle is the cycle after i_enable is sampled high in IDLE.
- Window end → o_valid high 1 cycle after the last sample of the window.
- Window period is exactly 2^Lq cycles; L=0 gives a 1-cycle window with w=MAXW every cycle.
- Reset mid-window discards all state; no snapshot is emitted.

## Test plan
- DATA_W=16, TIME_W=8, N_CH=2, L=2, x=2'b11, y=1 constant, i_ready=1 → after 4 RUN cycles the snapshot shows:
  - all countX, countIsect, countY = 700 (255+255+127+63).
  - countSymdiff = 0.
  - o_valid pulses 1 cycle every 4.
- L=8, x[0]=1, x[1]=0, y=0 for one window → countX[0]=43435, countX[1]=0, countSymdiff[0]=43435, countY=0.
- L=0, y toggling, i_ready=1 → a snapshot every cycle, countY alternating 255/0, o_missed never set.
- L=1, i_ready=0 for 3 windows, then 1 → o_valid stays 1 and shows the latest window; o_missed=1 until the accept edge, then 0.
- Drop i_enable at t=1 of an L=3 window → window completes through t=7, one snapshot, then IDLE with o_busy=0. Change L mid-window → takes effect on the next window only.
- Assert i_rstn low mid-window with o_valid=1 → all outputs 0 immediately (asynchronous); after release, no snapshot until a full new window completes.
